// File: rtl/div_share_ctrl_if.sv
// rtl/div_share_ctrl_if.sv - requester, shared-divider and result signals of div_share_ctrl
interface div_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2
);
  logic [N_REQ-1:0]   i_Req;
  logic [13*N_REQ-1:0] i_Dividendo;
  logic [5*N_REQ-1:0] i_Divisor;
  logic [N_REQ-1:0]   o_Grant;
  logic [12:0]        o_Div_Dividendo;
  logic [4:0]         o_Div_Divisor;
  logic [9:0]         i_Div_Result;
  logic               o_Valid;
  logic               i_Ready;
  logic [9:0]         o_Result;
  logic [TAG_W-1:0]   o_Tag;
  logic               o_DivZero;
  logic               o_Busy;

  modport slave (
    input  i_Req, i_Dividendo, i_Divisor, i_Div_Result, i_Ready,
    output o_Grant, o_Div_Dividendo, o_Div_Divisor, o_Valid, o_Result, o_Tag, o_DivZero, o_Busy
  );

  modport master (
    output i_Req, i_Dividendo, i_Divisor, i_Div_Result, i_Ready,
    input  o_Grant, o_Div_Dividendo, o_Div_Divisor, o_Valid, o_Result, o_Tag, o_DivZero, o_Busy
  );
endinterface

// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - round-robin sharing of one rounding divider among N_REQ requesters
// DIV_SHARE_PIPE_EN adds a second divider settling state (EXEC2).
module div_share_ctrl #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  div_share_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
    EXEC,
`ifdef DIV_SHARE_PIPE_EN
    EXEC2,
`endif
    CAPT,
    HOLD
  } state_t;

  state_t           state;
  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] sel_idx;
  logic [TAG_W:0]   cand;
  logic             found;
  logic [12:0]      sel_dvd;
  logic [4:0]       sel_dvs;
  logic [N_REQ-1:0] grant;
  logic [12:0]      div_dvd;
  logic [4:0]       div_dvs;
  logic [9:0]       result;
  logic             valid;
  logic             divzero;

  // First requester at or after the pointer, wrapping modulo N_REQ
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (TAG_W+1)'(i);
      if (cand >= (TAG_W+1)'(N_REQ))
        cand = cand - (TAG_W+1)'(N_REQ);
      if (!found && bus.i_Req[cand[TAG_W-1:0]]) begin
        found   = 1'b1;
        sel_idx = cand[TAG_W-1:0];
      end
    end
  end

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    grant   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_idx == TAG_W'(k)) begin
        sel_dvd = bus.i_Dividendo[13*k +: 13];
        sel_dvs = bus.i_Divisor[5*k +: 5];
      end
    end
    if (state == IDLE && found && !i_Rst)
      grant[sel_idx] = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= IDLE;
      ptr     <= '0;
      tag     <= '0;
      div_dvd <= '0;
      div_dvs <= '0;
      result  <= '0;
      valid   <= 1'b0;
      divzero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            tag <= sel_idx;
            ptr <= (sel_idx == TAG_W'(N_REQ-1)) ? '0 : sel_idx + 1'b1;
            // A zero divisor bypasses the divider, leaving its inputs untouched
            if (sel_dvs != '0) begin
              div_dvd <= sel_dvd;
              div_dvs <= sel_dvs;
              state   <= EXEC;
            end else begin
              result  <= 10'h3FF;
              divzero <= 1'b1;
              valid   <= 1'b1;
              state   <= HOLD;
            end
          end
        end
`ifdef DIV_SHARE_PIPE_EN
        EXEC:  state <= EXEC2;
        EXEC2: state <= CAPT;
`else
        EXEC:  state <= CAPT;
`endif
        CAPT: begin
          result  <= bus.i_Div_Result;
          divzero <= 1'b0;
          valid   <= 1'b1;
          state   <= HOLD;
        end
        HOLD: begin
          if (valid && bus.i_Ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_Grant         = grant;
  assign bus.o_Div_Dividendo = div_dvd;
  assign bus.o_Div_Divisor   = div_dvs;
  assign bus.o_Valid         = valid;
  assign bus.o_Result        = result;
  assign bus.o_Tag           = tag;
  assign bus.o_DivZero       = divzero;
  assign bus.o_Busy          = (state != IDLE);
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb/tb_div_share_ctrl.sv - directed and randomized self-checking bench for div_share_ctrl
module tb_div_share_ctrl;
  localparam int N  = 4;
  localparam int TW = 2;
`ifdef DIV_SHARE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  div_share_ctrl_if #(.N_REQ(N), .TAG_W(TW)) bus();
  div_share_ctrl #(.N_REQ(N), .TAG_W(TW)) dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));

  function automatic logic [9:0] rdiv(input logic [12:0] a, input logic [4:0] b);
    int q;
    if (b == 5'd0) return 10'h3FF;
    q = (int'(a) + int'(b) / 2) / int'(b);
    return q[9:0];
  endfunction

  assign bus.i_Div_Result = rdiv(bus.o_Div_Dividendo, bus.o_Div_Divisor);

  function automatic int idx_of(input logic [N-1:0] g);
    for (int k = 0; k < N; k++) if (g[k]) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s at cycle %0d", tag, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_op(input int k, input logic [12:0] a, input logic [4:0] b);
    bus.i_Dividendo[13*k +: 13] = a;
    bus.i_Divisor[5*k +: 5] = b;
  endtask

  function automatic logic [12:0] op_a(input int k);
    return bus.i_Dividendo[13*k +: 13];
  endfunction

  function automatic logic [4:0] op_b(input int k);
    return bus.i_Divisor[5*k +: 5];
  endfunction

  bit          pend [N];
  logic [12:0] ma   [N];
  logic [4:0]  mb   [N];
  int          gq[$];

  initial begin
    int n, ng, last, g, t, mptr, eg, j_tag, j_due;
    bit outst, exp_v, j_dz;
    logic [9:0]  j_res;
    logic [12:0] pdvd;
    logic [4:0]  pdvs;
    logic [N-1:0] exp_g;

    rst = 1'b1;
    bus.i_Req = '0;
    bus.i_Dividendo = '0;
    bus.i_Divisor = '0;
    bus.i_Ready = 1'b0;
    tick; tick;
    chk("rst_grant", bus.o_Grant === 4'b0000);
    chk("rst_valid", bus.o_Valid === 1'b0);
    chk("rst_result", bus.o_Result === 10'd0);
    chk("rst_tag", bus.o_Tag === 2'd0);
    chk("rst_divzero", bus.o_DivZero === 1'b0);
    chk("rst_busy", bus.o_Busy === 1'b0);
    chk("rst_div_dvd", bus.o_Div_Dividendo === 13'd0);
    chk("rst_div_dvs", bus.o_Div_Divisor === 5'd0);
    rst = 1'b0;

    set_op(0, 13'd1000, 5'd7);
    bus.i_Req = 4'b0001;
    bus.i_Ready = 1'b1;
    #1;
    chk("t1_grant", bus.o_Grant === 4'b0001);
    tick;
    bus.i_Req = '0;
    #1;
    chk("t1_grant_once", bus.o_Grant === 4'b0000);
    chk("t1_div_dvd", bus.o_Div_Dividendo === 13'd1000);
    chk("t1_div_dvs", bus.o_Div_Divisor === 5'd7);
    chk("t1_busy", bus.o_Busy === 1'b1);
    n = 1;
    while (!bus.o_Valid && n < 10) begin tick; n++; end
    chk("t1_latency", n == LAT + 1);
    chk("t1_result", bus.o_Result === 10'd143);
    chk("t1_tag", bus.o_Tag === 2'd0);
    chk("t1_divzero", bus.o_DivZero === 1'b0);
    tick;
    chk("t1_accept_valid", bus.o_Valid === 1'b0);
    chk("t1_accept_busy", bus.o_Busy === 1'b0);

    rst = 1'b1; tick; rst = 1'b0;
    for (int k = 0; k < N; k++) set_op(k, 13'(100 * (k + 1) + k), 5'(k + 3));
    bus.i_Req = 4'b1111;
    bus.i_Ready = 1'b1;
    ng = 0; last = 0; gq.delete();
    for (int c = 0; c < 40 && ng < 5; c++) begin
      #1;
      if (bus.o_Valid && gq.size() > 0) begin
        t = gq.pop_front();
        chk("t2_tag", bus.o_Tag === TW'(t));
        chk("t2_result", bus.o_Result === rdiv(op_a(t), op_b(t)));
      end
      g = idx_of(bus.o_Grant);
      if (g >= 0) begin
        chk("t2_order", g == ng % N);
        if (ng > 0) chk("t2_spacing", cyc - last == LAT + 2);
        last = cyc;
        gq.push_back(g);
        ng++;
      end
      tick;
    end
    chk("t2_grants", ng == 5);
    bus.i_Req = '0;
    for (int i = 0; i < 12 && bus.o_Busy; i++) tick;
    chk("t2_drain", bus.o_Busy === 1'b0);

    pdvd = bus.o_Div_Dividendo;
    pdvs = bus.o_Div_Divisor;
    bus.i_Ready = 1'b0;
    set_op(2, 13'd555, 5'd0);
    bus.i_Req = 4'b0100;
    #1;
    chk("t3_grant", bus.o_Grant === 4'b0100);
    tick;
    bus.i_Req = 4'b1011;
    #1;
    chk("t3_valid", bus.o_Valid === 1'b1);
    chk("t3_result", bus.o_Result === 10'h3FF);
    chk("t3_divzero", bus.o_DivZero === 1'b1);
    chk("t3_tag", bus.o_Tag === 2'd2);
    chk("t3_div_dvd_kept", bus.o_Div_Dividendo === pdvd);
    chk("t3_div_dvs_kept", bus.o_Div_Divisor === pdvs);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_valid", bus.o_Valid === 1'b1);
      chk("bp_result", bus.o_Result === 10'h3FF);
      chk("bp_tag", bus.o_Tag === 2'd2);
      chk("bp_grant", bus.o_Grant === 4'b0000);
      chk("bp_busy", bus.o_Busy === 1'b1);
    end
    bus.i_Ready = 1'b1;
    #1;
    chk("bp_accept_no_grant", bus.o_Grant === 4'b0000);
    tick;
    chk("bp_accepted", bus.o_Valid === 1'b0);
    chk("bp_next_grant", bus.o_Grant === 4'b1000);

    rst = 1'b1; bus.i_Req = '0; tick; rst = 1'b0;
    set_op(2, 13'd900, 5'd9);
    bus.i_Req = 4'b0110;
    #1;
    chk("t4_grant", bus.o_Grant === 4'b0010);
    tick;
    rst = 1'b1;
    tick;
    chk("t4_rst_valid", bus.o_Valid === 1'b0);
    chk("t4_rst_busy", bus.o_Busy === 1'b0);
    chk("t4_rst_grant", bus.o_Grant === 4'b0000);
    rst = 1'b0;
    #1;
    chk("t4_regrant", bus.o_Grant === 4'b0010);
    tick;
    bus.i_Req = '0;
    n = 1;
    while (!bus.o_Valid && n < 10) begin tick; n++; end
    chk("t4_latency", n == LAT + 1);
    chk("t4_tag", bus.o_Tag === 2'd1);
    chk("t4_result", bus.o_Result === rdiv(op_a(1), op_b(1)));
    tick;

    rst = 1'b1; tick; rst = 1'b0;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    mptr = 0; outst = 1'b0;
    j_tag = 0; j_due = 0; j_dz = 1'b0; j_res = '0;
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(2) == 0) begin
          pend[k] = 1'b1;
          ma[k] = 13'($urandom);
          mb[k] = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
          set_op(k, ma[k], mb[k]);
        end
        bus.i_Req[k] = pend[k];
      end
      bus.i_Ready = ($urandom_range(3) != 0);
      #1;
      exp_v = outst && (cyc >= j_due);
      chk("rnd_busy", bus.o_Busy === outst);
      chk("rnd_valid", bus.o_Valid === exp_v);
      if (exp_v) begin
        chk("rnd_result", bus.o_Result === j_res);
        chk("rnd_tag", bus.o_Tag === TW'(j_tag));
        chk("rnd_divzero", bus.o_DivZero === j_dz);
      end
      eg = -1;
      if (!outst)
        for (int i = 0; i < N; i++)
          if (eg < 0 && pend[(mptr + i) % N]) eg = (mptr + i) % N;
      exp_g = (eg < 0) ? '0 : N'(1 << eg);
      chk("rnd_grant", bus.o_Grant === exp_g);
      if (exp_v && bus.i_Ready) begin
        outst = 1'b0;
      end else if (eg >= 0) begin
        outst = 1'b1;
        j_tag = eg;
        j_res = rdiv(ma[eg], mb[eg]);
        j_dz  = (mb[eg] == 5'd0);
        j_due = cyc + 1 + (j_dz ? 0 : LAT);
        pend[eg] = 1'b0;
        mptr = (eg + 1) % N;
      end
      tick;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Round-robin controller that shares one combinational rounding divider (13-bit dividend, 5-bit divisor, 10-bit rounded quotient) among N_REQ requesters.
- Accepts one request at a time, registers the operands onto the divider input port, and captures the divider output one cycle later.
- Presents the result to a single consumer with a tag identifying the requester, using a valid/ready handshake.
- Traps divide-by-zero without using the divider.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TAG_W, 2, width of the requester tag; equals clog2(N_REQ).

Ports:
- i_Clk  in  1  clock; all state updates on its rising edge.
- i_Rst  in  1  reset; synchronous, active-high.
- i_Req  in  N_REQ  request level per requester; held high until granted.
- i_Dividendo  in  13*N_REQ  flat operand bus; requester k occupies bits [13k+12:13k].
- i_Divisor  in  5*N_REQ  flat operand bus; requester k occupies bits [5k+4:5k].
- o_Grant  out  N_REQ  one-hot accept strobe; operands of the granted requester are captured on that edge.
- o_Div_Dividendo  out  13  registered dividend driven to the shared divider.
- o_Div_Divisor  out  5  registered divisor driven to the shared divider.
- i_Div_Result  in  10  combinational result returned by the divider.
- o_Valid  out  1  result available.
- i_Ready  in  1  consumer accepts the result.
- o_Result  out  10  captured quotient.
- o_Tag  out  TAG_W  index of the requester that owns o_Result.
- o_DivZero  out  1  result came from a zero divisor.
- o_Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset:
  - State goes to IDLE; RR pointer = 0.
  - o_Grant = 0, o_Valid = 0, o_Result = 0, o_Tag = 0, o_DivZero = 0, o_Busy = 0, o_Div_Dividendo = 0, o_Div_Divisor = 0.
  - Reset mid-operation discards the in-flight job without a result or grant; the requester must re-request.
- States: IDLE, EXEC, CAPT, HOLD.
- IDLE:
  - Arbitration searches i_Req starting at the pointer and wrapping modulo N_REQ.
  - o_Grant[k] is combinational and high only in IDLE for the selected k.
  - On that edge: operands of k are latched into o_Div_*, tag <= k, pointer <= (k+1) mod N_REQ.
  - If the divisor is nonzero, go to EXEC. If the divisor is 0, go to HOLD with o_Result = 10'h3FF, o_DivZero = 1, o_Valid = 1 (divider unused).
  - No request: remain in IDLE.
- EXEC: one settling cycle for the divider; unconditional transition to CAPT.
- CAPT: o_Result <= i_Div_Result, o_DivZero <= 0, o_Valid <= 1, go to HOLD.
- HOLD:
  - o_Result, o_Tag and o_DivZero stay stable while o_Valid is high.
  - On o_Valid & i_Ready: o_Valid <= 0 and the state returns to IDLE. No new grant is issued in that same cycle; the next grant comes at the earliest one cycle later.
- Latency from grant edge to o_Valid high:
  - Normal: 2 cycles.
  - Divide-by-zero: 1 cycle.
  - Throughput: at most one job per 4 cycles with i_Ready tied high.
- o_Div_* hold their last value outside EXEC/CAPT; they are not zeroed.
- Simultaneous requests: the pointer alone decides. A requester dropping i_Req before being granted is simply not served. A requester that keeps i_Req high after a grant is treated as a new request.
- N_REQ = 1: the pointer stays 0 and o_Tag is always 0.

Optional Feature:
- Macro: DIV_SHARE_PIPE_EN.
- Defined:
  - Adds a state EXEC2 between EXEC and CAPT, giving the divider two cycles to settle.
  - Normal latency becomes 3 cycles; divide-by-zero latency is unchanged.
- Undefined: the states and latency are exactly as in Behaviour.

Test Plan:
- Reset, then single job: i_Req = 4'b0001, dividend 1000, divisor 7, model returns 143 → o_Grant = 0001 for 1 cycle; o_Valid 2 cycles later with o_Result = 143, o_Tag = 0, o_DivZero = 0.
- All four request continuously, i_Ready = 1 → grant order 0,1,2,3,0; each o_Tag matches; a grant every 4 cycles.
- Divisor 0 from requester 2 → o_Valid 1 cycle after grant with o_Result = 3FF, o_DivZero = 1, o_Tag = 2; the divider inputs keep their previous values.
- Backpressure: i_Ready = 0 for 5 cycles after o_Valid → o_Result and o_Tag stay stable, no grants, o_Busy = 1; i_Ready = 1 → result accepted, next grant one cycle later.
- i_Rst asserted during EXEC → next cycle o_Valid = 0, o_Busy = 0, pointer = 0; the same request then restarts from the grant.
- With DIV_SHARE_PIPE_EN, repeat the single-job test → o_Valid 3 cycles after grant.
